if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage: the producer side of the IF/ID pipeline register.
//   Holds the fetch PC and runs a req/ack handshake with instruction memory.
//   Every cycle it presents {ID_Flush, PC+4, inst} for IF/ID to sample.
//   IF/ID has no write enable, so stalls are realised by holding these outputs.
// PARAMETERS
//   RESET_PC  32'h0000_0000  first fetch address after reset release
//   NOP_INST  32'h0000_0000  instruction word driven with every bubble
// PORTS
//   clk_i          in   1   clock, rising edge
//   rst_i          in   1   reset, asynchronous, active-low
//   stall_i        in   1   hazard unit: hold current outputs (load-use)
//   redirect_i     in   1   taken branch/jump: flush and refetch
//   redirect_pc_i  in   32  redirect target; bits [1:0] forced to 0
//   imem_req_o     out  1   fetch request; held high until imem_ack_i
//   imem_addr_o    out  32  fetch address; stable while imem_req_o=1
//   imem_ack_i     in   1   data valid, earliest 1 cycle after req rises
//   imem_data_i    in   32  instruction word, valid when imem_ack_i=1
//   ID_Flush_o     out  1   1 = bubble in IF/ID
//   PC_o           out  32  fetched PC + 4 (to IF/ID PC_i)
//   inst_o         out  32  fetched instruction (to IF/ID inst_i)
// BEHAVIOUR
//   - Reset: ID_Flush_o=1, PC_o=0, inst_o=NOP_INST, imem_req_o=0, fetch_pc=RESET_PC, state IDLE, buffer empty.
//   - All outputs registered. imem_addr_o = fetch_pc.
//   - States: IDLE, REQ, BUF, DRAIN. imem_req_o=1 only in REQ and DRAIN.
//   - IDLE: go to REQ on the first clock after reset release; outputs stay a bubble.
//   - REQ with ack and stall_i=0: next outputs are {0, fetch_pc+4, imem_data_i}; fetch_pc += 4; stay REQ.
//   - REQ with ack and stall_i=1: outputs held; data and PC latched into the 1-entry buffer; go BUF.
//   - REQ without ack: stall_i=1 holds the outputs; stall_i=0 drives a bubble {1, PC_o held, NOP_INST}.
//   - BUF: req low. When stall_i=0, deliver the buffered entry as above, fetch_pc += 4, go REQ. Otherwise hold.
//   - Redirect (highest priority; overrides stall_i in every state):
//     - next outputs are a bubble; fetch_pc <= {redirect_pc_i[31:2], 2'b00}; buffer cleared.
//     - In REQ with no ack that cycle: go DRAIN. Old request stays asserted with the old address.
//     - In REQ with ack that same cycle: the data is discarded; go REQ.
//     - In BUF or IDLE: go REQ.
//   - DRAIN: on ack, discard the data and go REQ (the new address appears the next cycle).
//     A redirect in DRAIN only updates fetch_pc.
//     Outputs are a bubble unless stall_i=1 and no redirect, in which case they are held.
//   - Latency: ack at cycle n means the instruction is on the outputs at n+1 (if not stalled).
//   - PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
//   - Async reset mid-transaction: imem_req_o drops immediately.
//     A late ack arriving in IDLE is ignored.
// STRUCTURE
//   - Shared pipeline package holds: the state enum {IDLE,REQ,BUF,DRAIN}, the NOP word, the default reset PC, and the instruction width constant 32.
//   - No sub-module. The 1-entry hold buffer and the FSM stay inline (~200 lines).
// TESTING
//   1. Reset, then ack every cycle, no stall -> addresses 0,4,8,... Outputs {0,4,inst@0} at cycle after first ack.
//   2. stall_i=1 for 3 cycles while ack arrives -> outputs held 3 cycles; BUF entered; buffered inst delivered the cycle after stall drops, no lost or duplicated fetch.
//   3. redirect_i=1, target 32'h0000_0103 while req outstanding -> DRAIN. Old addr held until ack, that data dropped; next req addr 0x100; ID_Flush_o=1 until the 0x100 instruction.
//   4. redirect_i and imem_ack_i in the same cycle with stall_i=1 -> bubble next cycle (flush beats stall), acked data discarded, next req addr = target.
//   5. fetch_pc=32'hFFFF_FFFC, ack -> PC_o=0, next imem_addr_o=0.
//   6. rst_i low asynchronously mid-REQ -> imem_req_o=0 and ID_Flush_o=1 before next clock edge; after release the first fetch is at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_unit_pkg
// Brief  : Shared pipeline definitions for the instruction-fetch stage:
//          fetch FSM states, instruction width, NOP word and reset PC.
// Rev    : 1.0  initial release
// ============================================================================
package if_fetch_unit_pkg;

    localparam int c_INST_W = 32;

    localparam logic [c_INST_W-1:0] c_NOP_INST = 32'h0000_0000;
    localparam logic [c_INST_W-1:0] c_RESET_PC = 32'h0000_0000;

    // IDLE  : just out of reset, no request yet
    // REQ   : request outstanding at the current fetch address
    // BUF   : one acked instruction parked while the pipeline is stalled
    // DRAIN : waiting out a request made obsolete by a redirect
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BUF   = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_unit_if
// Brief  : Instruction-memory req/ack bus. The fetch unit is the master,
//          the instruction memory is the slave.
// Rev    : 1.0  initial release
// ============================================================================
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic                imem_req_o;
    logic [c_INST_W-1:0] imem_addr_o;
    logic                imem_ack_i;
    logic [c_INST_W-1:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );

endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_unit
// Brief  : Instruction-fetch stage feeding the IF/ID register. Owns the fetch
//          PC, runs the req/ack handshake with instruction memory, parks one
//          instruction while stalled and flushes on redirect.
// Rev    : 1.0  initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [c_INST_W-1:0] RESET_PC = c_RESET_PC,
    parameter logic [c_INST_W-1:0] NOP_INST = c_NOP_INST
) (
    input  wire                  clk_i,
    input  wire                  rst_i,
    input  wire                  stall_i,
    input  wire                  redirect_i,
    input  wire [c_INST_W-1:0]   redirect_pc_i,
    if_fetch_unit_if.master      imem,
    output logic                 ID_Flush_o,
    output logic [c_INST_W-1:0]  PC_o,
    output logic [c_INST_W-1:0]  inst_o
);

    fetch_state_t        r_state,     w_state_next;
    logic [c_INST_W-1:0] r_fetch_pc,  w_fetch_pc_next;
    logic                r_buf_valid, w_buf_valid_next;
    logic [c_INST_W-1:0] r_buf_data,  w_buf_data_next;
    logic [c_INST_W-1:0] r_buf_pc,    w_buf_pc_next;
    logic                r_flush,     w_flush_next;
    logic [c_INST_W-1:0] r_pc,        w_pc_next;
    logic [c_INST_W-1:0] r_inst,      w_inst_next;
    logic                r_req;
    logic [c_INST_W-1:0] r_addr;

    logic [c_INST_W-1:0] w_redirect_pc;
    logic [c_INST_W-1:0] w_fetch_pc_plus4;

    // Targets are word aligned; PC arithmetic wraps modulo 2^32.
    assign w_redirect_pc    = redirect_pc_i & ~32'd3;
    assign w_fetch_pc_plus4 = r_fetch_pc + 32'd4;

    // Next-state, fetch PC, hold buffer and IF/ID output selection.
    always_comb begin
        w_state_next     = r_state;
        w_fetch_pc_next  = r_fetch_pc;
        w_buf_valid_next = r_buf_valid;
        w_buf_data_next  = r_buf_data;
        w_buf_pc_next    = r_buf_pc;
        w_flush_next     = r_flush;
        w_pc_next        = r_pc;
        w_inst_next      = r_inst;

        case (r_state)
            IDLE: begin
                // A late ack from before reset is ignored here.
                w_state_next = REQ;
                w_flush_next = 1'b1;
                w_inst_next  = NOP_INST;
                if (redirect_i) begin
                    w_fetch_pc_next  = w_redirect_pc;
                    w_buf_valid_next = 1'b0;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    // Flush beats stall; any data acked this cycle is dropped.
                    w_flush_next     = 1'b1;
                    w_inst_next      = NOP_INST;
                    w_fetch_pc_next  = w_redirect_pc;
                    w_buf_valid_next = 1'b0;
                    w_state_next     = imem.imem_ack_i ? REQ : DRAIN;
                end else if (imem.imem_ack_i) begin
                    if (!stall_i) begin
                        w_flush_next    = 1'b0;
                        w_pc_next       = w_fetch_pc_plus4;
                        w_inst_next     = imem.imem_data_i;
                        w_fetch_pc_next = w_fetch_pc_plus4;
                    end else begin
                        // Park the word; IF/ID keeps showing the old one.
                        w_buf_valid_next = 1'b1;
                        w_buf_data_next  = imem.imem_data_i;
                        w_buf_pc_next    = w_fetch_pc_plus4;
                        w_state_next     = BUF;
                    end
                end else if (!stall_i) begin
                    w_flush_next = 1'b1;
                    w_inst_next  = NOP_INST;
                end
            end
            BUF: begin
                if (redirect_i) begin
                    w_flush_next     = 1'b1;
                    w_inst_next      = NOP_INST;
                    w_fetch_pc_next  = w_redirect_pc;
                    w_buf_valid_next = 1'b0;
                    w_state_next     = REQ;
                end else if (!stall_i) begin
                    w_flush_next     = !r_buf_valid;
                    w_pc_next        = r_buf_pc;
                    w_inst_next      = r_buf_valid ? r_buf_data : NOP_INST;
                    w_fetch_pc_next  = w_fetch_pc_plus4;
                    w_buf_valid_next = 1'b0;
                    w_state_next     = REQ;
                end
            end
            DRAIN: begin
                // The stale request stays on the bus; only the target moves.
                if (redirect_i) begin
                    w_fetch_pc_next = w_redirect_pc;
                end
                if (redirect_i || !stall_i) begin
                    w_flush_next = 1'b1;
                    w_inst_next  = NOP_INST;
                end
                if (imem.imem_ack_i) begin
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, buffer and registered outputs; async reset kills the request at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_buf_valid <= 1'b0;
            r_buf_data  <= NOP_INST;
            r_buf_pc    <= '0;
            r_flush     <= 1'b1;
            r_pc        <= '0;
            r_inst      <= NOP_INST;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_buf_valid <= w_buf_valid_next;
            r_buf_data  <= w_buf_data_next;
            r_buf_pc    <= w_buf_pc_next;
            r_flush     <= w_flush_next;
            r_pc        <= w_pc_next;
            r_inst      <= w_inst_next;
            r_req       <= (w_state_next == REQ) || (w_state_next == DRAIN);
            // A new address is only launched when (re)entering REQ.
            if (w_state_next == REQ) begin
                r_addr <= w_fetch_pc_next;
            end
        end
    end

    assign imem.imem_req_o  = r_req;
    assign imem.imem_addr_o = r_addr;
    assign ID_Flush_o       = r_flush;
    assign PC_o             = r_pc;
    assign inst_o           = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_if_fetch_unit
// Brief  : Bench for if_fetch_unit. A random phase drives stall/redirect and a
//          random-latency memory, with a program-order scoreboard; a directed
//          phase walks the stall, redirect, wrap and async-reset corners.
// Rev    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] c_RST_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam int          c_K_FREE = 0;
    localparam int          c_K_HOLD = 1;
    localparam int          c_K_REDIR = 2;

    typedef struct {
        int          kind;
        logic [31:0] target;
    } rec_t;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ID_Flush_o;
    logic [31:0] PC_o;
    logic [31:0] inst_o;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(
        .RESET_PC (c_RST_PC),
        .NOP_INST (c_NOP)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem_bus),
        .ID_Flush_o    (ID_Flush_o),
        .PC_o          (PC_o),
        .inst_o        (inst_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    rec_t        exp_q[$];
    rec_t        rec;
    bit          mon_en = 1'b0;
    logic [31:0] stream_pc;
    int          deliveries = 0;
    logic        p_flush;
    logic [31:0] p_pc;
    logic [31:0] p_inst;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: each clock consumes one expected-effect record.
    always @(posedge clk_i) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got empty queue expected a record at %0t", $time);
            end else begin
                rec = exp_q.pop_front();
                if (rec.kind == c_K_HOLD) begin
                    check("hold_flush", 32'(ID_Flush_o), 32'(p_flush));
                    check("hold_pc", PC_o, p_pc);
                    check("hold_inst", inst_o, p_inst);
                end else if (rec.kind == c_K_REDIR) begin
                    check("redir_flush", 32'(ID_Flush_o), 32'd1);
                    check("redir_inst", inst_o, c_NOP);
                    check("redir_pc", PC_o, p_pc);
                    stream_pc = rec.target & 32'hFFFF_FFFC;
                end else if (ID_Flush_o) begin
                    check("bubble_inst", inst_o, c_NOP);
                    check("bubble_pc", PC_o, p_pc);
                end else begin
                    check("stream_pc", PC_o, stream_pc + 32'd4);
                    check("stream_inst", inst_o, mem_word(stream_pc));
                    stream_pc  = stream_pc + 32'd4;
                    deliveries++;
                end
            end
        end
        p_flush = ID_Flush_o;
        p_pc    = PC_o;
        p_inst  = inst_o;
    end

    initial begin
        logic        pv_req;
        logic        pv_ack;
        logic [31:0] pv_addr;
        logic [31:0] tgt;
        rec_t        r;

        rst_i                = 1'b0;
        stall_i              = 1'b0;
        redirect_i           = 1'b0;
        redirect_pc_i        = '0;
        imem_bus.imem_ack_i  = 1'b0;
        imem_bus.imem_data_i = '0;
        pv_req  = 1'b0;
        pv_ack  = 1'b0;
        pv_addr = '0;

        // ---------------- random phase ----------------
        repeat (3) @(posedge clk_i);
        #1;
        rst_i     = 1'b1;
        stream_pc = c_RST_PC;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            mon_en     = 1'b1;
            stall_i    = ($urandom_range(0, 99) < 30);
            redirect_i = ($urandom_range(0, 99) < 5);
            tgt        = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 | (tgt & 32'h1F);
            redirect_pc_i = tgt;
            if (pv_req && !pv_ack && imem_bus.imem_req_o)
                check("addr_stable", imem_bus.imem_addr_o, pv_addr);
            imem_bus.imem_ack_i  = imem_bus.imem_req_o && ($urandom_range(0, 99) < 60);
            imem_bus.imem_data_i = imem_bus.imem_ack_i ? mem_word(imem_bus.imem_addr_o) : $urandom;
            pv_req  = imem_bus.imem_req_o;
            pv_ack  = imem_bus.imem_ack_i;
            pv_addr = imem_bus.imem_addr_o;
            r.kind   = redirect_i ? c_K_REDIR : (stall_i ? c_K_HOLD : c_K_FREE);
            r.target = tgt;
            exp_q.push_back(r);
        end
        @(posedge clk_i);
        #3;
        mon_en = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("sb_progress", 32'(deliveries >= 100), 32'd1);

        // ---------------- directed phase ----------------
        rst_i                = 1'b0;
        stall_i              = 1'b0;
        redirect_i           = 1'b0;
        imem_bus.imem_ack_i  = 1'b0;
        imem_bus.imem_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_flush", 32'(ID_Flush_o), 32'd1);
        check("rst_pc", PC_o, 32'd0);
        check("rst_inst", inst_o, c_NOP);
        check("rst_req", 32'(imem_bus.imem_req_o), 32'd0);
        rst_i = 1'b1;
        step();
        check("t1_req", 32'(imem_bus.imem_req_o), 32'd1);
        check("t1_addr0", imem_bus.imem_addr_o, 32'h0);
        check("t1_bubble", 32'(ID_Flush_o), 32'd1);

        // 1: back-to-back acks, one-cycle latency
        imem_bus.imem_ack_i  = 1'b1;
        imem_bus.imem_data_i = mem_word(32'h0);
        step();
        check("t1_flush", 32'(ID_Flush_o), 32'd0);
        check("t1_pc", PC_o, 32'h4);
        check("t1_inst", inst_o, mem_word(32'h0));
        check("t1_addr4", imem_bus.imem_addr_o, 32'h4);
        imem_bus.imem_data_i = mem_word(32'h4);
        step();
        check("t1_pc2", PC_o, 32'h8);
        check("t1_inst2", inst_o, mem_word(32'h4));
        check("t1_addr8", imem_bus.imem_addr_o, 32'h8);

        // 2: stall while ack arrives -> buffer, hold 3 cycles, then deliver
        stall_i              = 1'b1;
        imem_bus.imem_data_i = mem_word(32'h8);
        step();
        check("t2_hold_pc", PC_o, 32'h8);
        check("t2_hold_inst", inst_o, mem_word(32'h4));
        check("t2_req_low", 32'(imem_bus.imem_req_o), 32'd0);
        imem_bus.imem_ack_i  = 1'b0;
        imem_bus.imem_data_i = $urandom;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t2_hold_pc_n", PC_o, 32'h8);
            check("t2_hold_flush", 32'(ID_Flush_o), 32'd0);
        end
        stall_i = 1'b0;
        step();
        check("t2_buf_pc", PC_o, 32'hC);
        check("t2_buf_inst", inst_o, mem_word(32'h8));
        check("t2_req", 32'(imem_bus.imem_req_o), 32'd1);
        check("t2_addr", imem_bus.imem_addr_o, 32'hC);

        // 3: redirect with request outstanding -> drain old, refetch 0x100
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        step();
        check("t3_flush", 32'(ID_Flush_o), 32'd1);
        check("t3_inst", inst_o, c_NOP);
        check("t3_pc_held", PC_o, 32'hC);
        check("t3_old_addr", imem_bus.imem_addr_o, 32'hC);
        redirect_i    = 1'b0;
        redirect_pc_i = $urandom;
        step();
        check("t3_old_addr2", imem_bus.imem_addr_o, 32'hC);
        check("t3_req", 32'(imem_bus.imem_req_o), 32'd1);
        imem_bus.imem_ack_i  = 1'b1;
        imem_bus.imem_data_i = mem_word(32'hC);
        step();
        check("t3_new_addr", imem_bus.imem_addr_o, 32'h100);
        check("t3_drop", 32'(ID_Flush_o), 32'd1);
        imem_bus.imem_data_i = mem_word(32'h100);
        step();
        check("t3_tgt_flush", 32'(ID_Flush_o), 32'd0);
        check("t3_tgt_pc", PC_o, 32'h104);
        check("t3_tgt_inst", inst_o, mem_word(32'h100));

        // 4: redirect + ack + stall together -> flush wins, data dropped
        stall_i              = 1'b1;
        redirect_i           = 1'b1;
        redirect_pc_i        = 32'hFFFF_FFFC;
        imem_bus.imem_data_i = mem_word(32'h104);
        step();
        check("t4_flush", 32'(ID_Flush_o), 32'd1);
        check("t4_inst", inst_o, c_NOP);
        check("t4_addr", imem_bus.imem_addr_o, 32'hFFFF_FFFC);
        check("t4_req", 32'(imem_bus.imem_req_o), 32'd1);

        // 5: PC wraps at the top of the address space
        stall_i              = 1'b0;
        redirect_i           = 1'b0;
        imem_bus.imem_data_i = mem_word(32'hFFFF_FFFC);
        step();
        check("t5_flush", 32'(ID_Flush_o), 32'd0);
        check("t5_pc_wrap", PC_o, 32'h0);
        check("t5_inst", inst_o, mem_word(32'hFFFF_FFFC));
        check("t5_addr_wrap", imem_bus.imem_addr_o, 32'h0);
        imem_bus.imem_data_i = mem_word(32'h0);
        step();
        check("t5_pc4", PC_o, 32'h4);

        // 6: async reset mid-request, late ack ignored after release
        imem_bus.imem_ack_i = 1'b0;
        #2;
        rst_i                = 1'b0;
        imem_bus.imem_ack_i  = 1'b1;
        imem_bus.imem_data_i = mem_word(32'h4);
        #1;
        check("t6_req_drop", 32'(imem_bus.imem_req_o), 32'd0);
        check("t6_flush", 32'(ID_Flush_o), 32'd1);
        check("t6_pc", PC_o, 32'h0);
        check("t6_inst", inst_o, c_NOP);
        step();
        rst_i = 1'b1;
        step();
        check("t6_req", 32'(imem_bus.imem_req_o), 32'd1);
        check("t6_addr", imem_bus.imem_addr_o, c_RST_PC);
        check("t6_late_ack", 32'(ID_Flush_o), 32'd1);
        imem_bus.imem_ack_i = 1'b0;
        step();
        check("t6_bubble", 32'(ID_Flush_o), 32'd1);
        check("t6_addr_hold", imem_bus.imem_addr_o, c_RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
